// File: rtl/spi_pkg.sv
// Shared definitions for the SPI host-link receive path: FSM encoding and
// SUMP opcode constants.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RX_DATA = 2'd1,
    EXEC    = 2'd2
  } state_t;

  localparam logic [7:0]  OP_RESET    = 8'h00;
  localparam logic [7:0]  OP_RUN      = 8'h01;
  localparam logic [7:0]  OP_ID       = 8'h02;
  localparam logic [7:0]  OP_METADATA = 8'h04;
  localparam logic [7:0]  OP_DATAIN   = 8'h06;
  localparam logic [31:0] SLA1_ID     = 32'h534c4131;

  // Opcode bit that marks a long command (opcode + 4 payload bytes).
  localparam int LONG_BIT = 7;

  localparam int DATA_BYTES = 4;

endpackage

// File: rtl/spi_receiver_if.sv
// Bundle of SPI pins and decoded-command outputs of the receiver.
// The receiver sits on the slave modport; the PIC side / bench on master.
interface spi_receiver_if;
  import spi_pkg::*;

  logic        sclk;
  logic        cs;
  logic        mosi;

  // Handshake: execute is a single-cycle strobe with no back-pressure; op and
  // data are valid during it, query_id / query_dataIn only ever coincide with
  // it, and byte_strobe pulses once per assembled byte independent of framing.
  logic [7:0]  op;
  logic [31:0] data;
  logic        execute;
  logic        query_id;
  logic        query_dataIn;
  logic        byte_strobe;
  state_t      state;

  modport master (
    output sclk, cs, mosi,
    input  op, data, execute, query_id, query_dataIn, byte_strobe, state
  );

  modport slave (
    input  sclk, cs, mosi,
    output op, data, execute, query_id, query_dataIn, byte_strobe, state
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, with an optional third
// register giving a one-cycle rising-edge pulse.
module spi_sync_edge #(
  parameter bit EDGE      = 1'b1,
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync,
  output logic rise
);

  logic [1:0] sync_ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff <= {2{RESET_VAL}};
    end else begin
      sync_ff <= {sync_ff[0], din};
    end
  end

  assign sync = sync_ff[1];

  generate
    if (EDGE) begin : g_edge
      logic prev;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          prev <= RESET_VAL;
        end else begin
          prev <= sync_ff[1];
        end
      end

      assign rise = sync_ff[1] & ~prev;
    end else begin : g_no_edge
      assign rise = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/spi_receiver.sv
// SPI slave receive path: oversamples the PIC's SPI pins, assembles MSB-first
// bytes and decodes SUMP short/long commands into an execute strobe.
module spi_receiver
  import spi_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000,
  parameter logic [7:0]  ID_OPCODE      = OP_ID,
  parameter logic [7:0]  DATAIN_OPCODE  = OP_DATAIN
) (
  input  logic           clock,
  input  logic           extReset_n,
  spi_receiver_if.slave  bus
);

  // Reset asserts asynchronously and releases on a clock edge.
  logic [1:0] rst_ff;
  logic       rst_n;

  always_ff @(posedge clock or negedge extReset_n) begin
    if (!extReset_n) begin
      rst_ff <= 2'b00;
    end else begin
      rst_ff <= {rst_ff[0], 1'b1};
    end
  end

  assign rst_n = rst_ff[1];

  logic sclk_sync;
  logic sclk_rise;
  logic cs_sync;
  logic unused_cs_rise;
  logic mosi_sync;
  logic unused_mosi_rise;

  spi_sync_edge #(.EDGE(1'b1), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk   (clock),
    .rst_n (rst_n),
    .din   (bus.sclk),
    .sync  (sclk_sync),
    .rise  (sclk_rise)
  );

  spi_sync_edge #(.EDGE(1'b1), .RESET_VAL(1'b1)) u_cs_sync (
    .clk   (clock),
    .rst_n (rst_n),
    .din   (bus.cs),
    .sync  (cs_sync),
    .rise  (unused_cs_rise)
  );

  spi_sync_edge #(.EDGE(1'b0), .RESET_VAL(1'b0)) u_mosi_sync (
    .clk   (clock),
    .rst_n (rst_n),
    .din   (bus.mosi),
    .sync  (mosi_sync),
    .rise  (unused_mosi_rise)
  );

  // Bit capture on the sclk rise; the transmitter moves mosi on the fall.
  // The eighth bit goes straight into rx_byte, so the shifter holds seven.
  logic [6:0] shreg;
  logic [2:0] bit_cnt;
  logic [7:0] rx_byte;
  logic       byte_done;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      rx_byte   <= '0;
      byte_done <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      if (cs_sync) begin
        bit_cnt <= '0;
      end else if (sclk_rise) begin
        shreg   <= {shreg[5:0], mosi_sync};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_byte   <= {shreg, mosi_sync};
          byte_done <= 1'b1;
        end
      end
    end
  end

  state_t      state, state_n;
  logic [7:0]  op_q, op_n;
  logic [31:0] data_q, data_n;
  logic [1:0]  idx, idx_n;
  logic [23:0] tcnt, tcnt_n;
  logic        pending, pending_n;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      op_q    <= '0;
      data_q  <= '0;
      idx     <= '0;
      tcnt    <= '0;
      pending <= 1'b0;
    end else begin
      state   <= state_n;
      op_q    <= op_n;
      data_q  <= data_n;
      idx     <= idx_n;
      tcnt    <= tcnt_n;
      pending <= pending_n;
    end
  end

  // In RX_DATA a completed byte wins over a same-cycle cs abort, and both win
  // over the inactivity timeout.
  always_comb begin
    state_n   = state;
    op_n      = op_q;
    data_n    = data_q;
    idx_n     = idx;
    tcnt_n    = '0;
    pending_n = 1'b0;

    case (state)
      IDLE: begin
        if (byte_done || pending) begin
          op_n = rx_byte;
          if (!rx_byte[LONG_BIT]) begin
            state_n = EXEC;
          end else begin
            idx_n   = '0;
            state_n = RX_DATA;
          end
        end
      end

      RX_DATA: begin
        if (byte_done) begin
          data_n[{idx, 3'b000} +: 8] = rx_byte;
          idx_n = idx + 2'd1;
          if (idx == 2'(DATA_BYTES - 1)) begin
            state_n = EXEC;
          end else if (cs_sync) begin
            state_n = IDLE;
          end
        end else if (cs_sync) begin
          state_n = IDLE;
        end else if (tcnt == TIMEOUT_CYCLES - 24'd1) begin
          state_n = IDLE;
        end else begin
          tcnt_n = tcnt + 24'd1;
        end
      end

      EXEC: begin
        state_n   = IDLE;
        pending_n = byte_done;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.op           = op_q;
  assign bus.data         = data_q;
  assign bus.execute      = (state == EXEC);
  assign bus.query_id     = (state == EXEC) && (op_q == ID_OPCODE);
  assign bus.query_dataIn = (state == EXEC) && (op_q == DATAIN_OPCODE);
  assign bus.byte_strobe  = byte_done;
  assign bus.state        = state;

endmodule
